// File: rtl/sha256_bit_sequencer.sv
// Timing master for the bit-serial SHA-256 core: bit clock, bit index, round index and
// block handshake. Optional pause input is enabled by defining SHA256_SEQ_PAUSE_EN.
module sha256_bit_sequencer #(
    parameter int W_WORD      = 32,
    parameter int N_ROUNDS    = 64,
    parameter int HALF_PERIOD = 2
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         start,
    input  logic                         abort,
`ifdef SHA256_SEQ_PAUSE_EN
    input  logic                         pause,
`endif
    output logic                         ready,
    output logic                         busy,
    output logic                         bclk,
    output logic [$clog2(W_WORD)-1:0]    counter,
    output logic [$clog2(N_ROUNDS)-1:0]  round,
    output logic                         word_first,
    output logic                         word_last,
    output logic                         sched_load,
    output logic                         flushing,
    output logic                         done
);

    localparam int CW = $clog2(W_WORD);
    localparam int RW = $clog2(N_ROUNDS);
    localparam logic [CW-1:0] CNT_MAX   = CW'(W_WORD - 1);
    localparam logic [RW-1:0] RND_MAX   = RW'(N_ROUNDS - 1);
    localparam logic [RW-1:0] RND_SCHED = RW'(16);
    localparam logic [7:0]    PH_MAX    = 8'(HALF_PERIOD - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_FLUSH = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t         state_r;
    state_t         state_s;
    logic [7:0]     phase_r;
    logic [7:0]     phase_s;
    logic           bclk_r;
    logic           bclk_s;
    logic [CW-1:0]  counter_r;
    logic [CW-1:0]  counter_s;
    logic [RW-1:0]  round_r;
    logic [RW-1:0]  round_s;
    logic           ready_r;
    logic           ready_s;
    logic           busy_r;
    logic           busy_s;
    logic           flushing_r;
    logic           flushing_s;
    logic           done_r;
    logic           done_s;

    logic           pause_s;
    logic           active_s;
    logic           word_end_s;

`ifdef SHA256_SEQ_PAUSE_EN
    assign pause_s = pause;
`else
    assign pause_s = 1'b0;
`endif

    assign active_s   = (state_r == S_RUN) || (state_r == S_FLUSH);
    // The last bit of a word ends on the edge where bclk falls with counter at its top value.
    assign word_end_s = active_s && !pause_s && (phase_r == PH_MAX) && bclk_r
                        && (counter_r == CNT_MAX);

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r    <= S_IDLE;
            phase_r    <= 8'd0;
            bclk_r     <= 1'b0;
            counter_r  <= {CW{1'b0}};
            round_r    <= {RW{1'b0}};
            ready_r    <= 1'b1;
            busy_r     <= 1'b0;
            flushing_r <= 1'b0;
            done_r     <= 1'b0;
        end else begin
            state_r    <= state_s;
            phase_r    <= phase_s;
            bclk_r     <= bclk_s;
            counter_r  <= counter_s;
            round_r    <= round_s;
            ready_r    <= ready_s;
            busy_r     <= busy_s;
            flushing_r <= flushing_s;
            done_r     <= done_s;
        end
    end

    // Next-state logic; abort wins over start and over normal progress.
    always_comb begin
        state_s = state_r;
        case (state_r)
            S_IDLE: begin
                if (start && !abort) begin
                    state_s = S_RUN;
                end else begin
                    state_s = S_IDLE;
                end
            end
            S_RUN: begin
                if (abort) begin
                    state_s = S_IDLE;
                end else if (word_end_s && (round_r == RND_MAX)) begin
                    state_s = S_FLUSH;
                end else begin
                    state_s = S_RUN;
                end
            end
            S_FLUSH: begin
                if (abort) begin
                    state_s = S_IDLE;
                end else if (word_end_s) begin
                    state_s = S_DONE;
                end else begin
                    state_s = S_FLUSH;
                end
            end
            S_DONE:  state_s = S_IDLE;
            default: state_s = S_IDLE;
        endcase
    end

    // Phase, bit clock, bit index and round; counter/round move only when bclk falls.
    always_comb begin
        phase_s   = phase_r;
        bclk_s    = bclk_r;
        counter_s = counter_r;
        round_s   = round_r;
        if (!active_s || abort) begin
            phase_s   = 8'd0;
            bclk_s    = 1'b0;
            counter_s = {CW{1'b0}};
            round_s   = {RW{1'b0}};
        end else if (pause_s) begin
            phase_s   = phase_r;
            bclk_s    = bclk_r;
        end else if (phase_r == PH_MAX) begin
            phase_s = 8'd0;
            bclk_s  = ~bclk_r;
            if (bclk_r) begin
                if (counter_r == CNT_MAX) begin
                    counter_s = {CW{1'b0}};
                    // Round saturates at its last value so FLUSH keeps reporting it.
                    if ((state_r == S_RUN) && (round_r != RND_MAX)) begin
                        round_s = round_r + RW'(1);
                    end else begin
                        round_s = round_r;
                    end
                end else begin
                    counter_s = counter_r + CW'(1);
                    round_s   = round_r;
                end
            end else begin
                counter_s = counter_r;
            end
        end else begin
            phase_s = phase_r + 8'd1;
        end
    end

    // Registered status outputs follow the state being entered.
    always_comb begin
        ready_s    = (state_s == S_IDLE);
        busy_s     = (state_s == S_RUN) || (state_s == S_FLUSH);
        flushing_s = (state_s == S_FLUSH);
        done_s     = (state_s == S_DONE);
    end

    assign ready      = ready_r;
    assign busy       = busy_r;
    assign bclk       = bclk_r;
    assign counter    = counter_r;
    assign round      = round_r;
    assign flushing   = flushing_r;
    assign done       = done_r;
    assign word_first = busy_r && (counter_r == {CW{1'b0}});
    assign word_last  = busy_r && (counter_r == CNT_MAX);
    assign sched_load = (state_r == S_RUN) && (round_r < RND_SCHED);

endmodule

// File: tb/tb_sha256_bit_sequencer.sv
// Scoreboard bench for sha256_bit_sequencer: a default instance and a HALF_PERIOD=1 instance.
module tb_sha256_bit_sequencer;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic       abort;
    logic       start1;
    logic       abort1;
`ifdef SHA256_SEQ_PAUSE_EN
    logic       pause;
    logic       pause1;
`endif

    logic       ready, busy, bclk, word_first, word_last, sched_load, flushing, done;
    logic [4:0] counter;
    logic [5:0] round;
    logic       ready1, busy1, bclk1, word_first1, word_last1, sched_load1, flushing1, done1;
    logic [4:0] counter1;
    logic [5:0] round1;

    int checks = 0;
    int errors = 0;
    int edge_cnt = 0;
    int t0 = 0;
    int q0[$];
    int q1[$];

    always #5 clk = ~clk;

    always @(posedge clk) edge_cnt <= edge_cnt + 1;

    sha256_bit_sequencer #(.W_WORD(32), .N_ROUNDS(64), .HALF_PERIOD(2)) u_dut (
        .clk(clk), .rst(rst), .start(start), .abort(abort),
`ifdef SHA256_SEQ_PAUSE_EN
        .pause(pause),
`endif
        .ready(ready), .busy(busy), .bclk(bclk), .counter(counter), .round(round),
        .word_first(word_first), .word_last(word_last), .sched_load(sched_load),
        .flushing(flushing), .done(done)
    );

    sha256_bit_sequencer #(.W_WORD(32), .N_ROUNDS(64), .HALF_PERIOD(1)) u_dut1 (
        .clk(clk), .rst(rst), .start(start1), .abort(abort1),
`ifdef SHA256_SEQ_PAUSE_EN
        .pause(pause1),
`endif
        .ready(ready1), .busy(busy1), .bclk(bclk1), .counter(counter1), .round(round1),
        .word_first(word_first1), .word_last(word_last1), .sched_load(sched_load1),
        .flushing(flushing1), .done(done1)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d (edge %0d)", name, act, exp, edge_cnt);
        end
    endtask

    task automatic goto(input int k);
        while (edge_cnt < t0 + k) @(negedge clk);
    endtask

    task automatic chk_idle(input string tag);
        chk({tag, "_ready"}, ready, 1);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_bclk"}, bclk, 0);
        chk({tag, "_counter"}, counter, 0);
        chk({tag, "_round"}, round, 0);
        chk({tag, "_done"}, done, 0);
        chk({tag, "_flushing"}, flushing, 0);
        chk({tag, "_sched"}, sched_load, 0);
    endtask

    // Monitor for the default instance: done scoreboard and bit-index model.
    initial begin
        logic       p_busy;
        logic       p_bclk;
        logic [4:0] p_cnt;
        logic [4:0] exp_c;
        int         exp_t;
        p_busy = 1'b0;
        p_bclk = 1'b0;
        p_cnt  = 5'd0;
        forever begin
            @(negedge clk);
            if (done === 1'b1) begin
                if (q0.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL done0_unexpected actual=done at edge %0d required=no done", edge_cnt);
                end else begin
                    exp_t = q0.pop_front();
                    chk("done0_time", edge_cnt, exp_t);
                end
            end
            if ((busy === 1'b1) && p_busy) begin
                exp_c = (p_bclk && (bclk === 1'b0)) ? p_cnt + 5'd1 : p_cnt;
                chk("counter0_model", counter, exp_c);
            end
            p_busy = (busy === 1'b1);
            p_bclk = (bclk === 1'b1);
            p_cnt  = counter;
        end
    end

    // Monitor for the HALF_PERIOD=1 instance: toggling, bit index, word_last width, round hold.
    initial begin
        logic       p_busy;
        logic       p_bclk;
        logic [4:0] p_cnt;
        logic [4:0] exp_c;
        int         exp_t;
        int         wl_run;
        p_busy = 1'b0;
        p_bclk = 1'b0;
        p_cnt  = 5'd0;
        wl_run = 0;
        forever begin
            @(negedge clk);
            if (done1 === 1'b1) begin
                if (q1.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL done1_unexpected actual=done at edge %0d required=no done", edge_cnt);
                end else begin
                    exp_t = q1.pop_front();
                    chk("done1_time", edge_cnt, exp_t);
                end
            end
            if ((busy1 === 1'b1) && p_busy) begin
                chk("bclk1_toggle", bclk1, !p_bclk);
                exp_c = (p_bclk && (bclk1 === 1'b0)) ? p_cnt + 5'd1 : p_cnt;
                chk("counter1_model", counter1, exp_c);
            end
            if (flushing1 === 1'b1) chk("round1_flush", round1, 63);
            if (word_last1 === 1'b1) begin
                wl_run++;
            end else if (wl_run != 0) begin
                chk("word_last1_len", wl_run, 2);
                wl_run = 0;
            end
            p_busy = (busy1 === 1'b1);
            p_bclk = (bclk1 === 1'b1);
            p_cnt  = counter1;
        end
    end

    initial begin
        #3000000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int lim;
        rst    = 1'b1;
        start  = 1'b0;
        abort  = 1'b0;
        start1 = 1'b0;
        abort1 = 1'b0;
`ifdef SHA256_SEQ_PAUSE_EN
        pause  = 1'b0;
        pause1 = 1'b0;
`endif
        repeat (3) @(negedge clk);
        rst = 1'b0;
        chk_idle("reset");

        // Block A: full run on both instances, start while busy and in DONE ignored.
        start  = 1'b1;
        start1 = 1'b1;
        @(negedge clk);
        start  = 1'b0;
        start1 = 1'b0;
        t0 = edge_cnt - 1;
        q0.push_back(t0 + 8321);
        q1.push_back(t0 + 4161);
        chk("a1_busy", busy, 1);
        chk("a1_ready", ready, 0);
        chk("a1_bclk", bclk, 0);
        chk("a1_sched", sched_load, 1);
        chk("a1_first", word_first, 1);
        goto(2);    chk("a2_bclk", bclk, 0);
        goto(3);    chk("a3_bclk_rise", bclk, 1);
                    chk("a3_counter", counter, 0);
        goto(5);    chk("a5_bclk", bclk, 0);
                    chk("a5_counter", counter, 1);
        goto(100);  start = 1'b1;
        goto(101);  start = 1'b0;
                    chk("a101_busy", busy, 1);
        goto(2048); chk("a2048_sched", sched_load, 1);
        goto(2049); chk("a2049_sched", sched_load, 0);
                    chk("a2049_round", round, 16);
                    chk("a2049_counter", counter, 0);
        goto(8192); chk("a8192_flushing", flushing, 0);
                    chk("a8192_round", round, 63);
                    chk("a8192_last", word_last, 1);
        goto(8193); chk("a8193_flushing", flushing, 1);
                    chk("a8193_round", round, 63);
                    chk("a8193_counter", counter, 0);
                    chk("a8193_sched", sched_load, 0);
                    chk("a8193_bclk", bclk, 0);
        goto(8320); chk("a8320_flushing", flushing, 1);
                    chk("a8320_last", word_last, 1);
        goto(8321); chk("a8321_done", done, 1);
                    chk("a8321_busy", busy, 0);
                    chk("a8321_flushing", flushing, 0);
                    chk("a8321_bclk", bclk, 0);
                    start = 1'b1;
        goto(8322); chk("a8322_ready", ready, 1);
                    chk("a8322_busy", busy, 0);
        goto(8323); start = 1'b0;
                    chk("b1_busy", busy, 1);

        // Block B: launched from the IDLE cycle after done, aborted at round 10 bit 5.
        t0  = t0 + 8322;
        lim = 0;
        while (!((round === 6'd10) && (counter === 5'd5)) && (lim < 5000)) begin
            @(negedge clk);
            lim++;
        end
        chk("b_abort_point_cycle", edge_cnt - t0, 1301);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        chk_idle("abort");
        repeat (20) @(negedge clk);
        chk("b_after_abort_ready", ready, 1);

        // Block C: reset during FLUSH.
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        t0 = edge_cnt - 1;
        goto(8203); chk("c_flushing", flushing, 1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk_idle("rstflush");
        repeat (5) @(negedge clk);

        // Block D: clean run, optionally with a 7-cycle pause while bclk is high.
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        t0 = edge_cnt - 1;
`ifdef SHA256_SEQ_PAUSE_EN
        q0.push_back(t0 + 8321 + 7);
        goto(3);
        chk("d_pause_bclk_pre", bclk, 1);
        pause = 1'b1;
        for (int i = 0; i < 7; i++) begin
            @(negedge clk);
            chk("d_pause_bclk", bclk, 1);
            chk("d_pause_counter", counter, 0);
            chk("d_pause_round", round, 0);
        end
        pause = 1'b0;
        goto(13);
        chk("d_resume_bclk", bclk, 0);
        chk("d_resume_counter", counter, 1);
`else
        q0.push_back(t0 + 8321);
`endif
        lim = 0;
        while ((q0.size() != 0) && (lim < 9000)) begin
            @(negedge clk);
            lim++;
        end
        repeat (5) @(negedge clk);
        chk("end_q0_empty", q0.size(), 0);
        chk("end_q1_empty", q1.size(), 0);
        chk("end_ready", ready, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/sha256_bit_sequencer.md
Name: sha256_bit_sequencer

Overview:
- Timing master for the bit-serial SHA-256 datapath. Generates the slow bit clock `bclk` and the bit-index `counter` used by every `rotl` delay line and serial adder.
- Tracks the round index and produces word-boundary and schedule-select strobes.
- Runs a start/done handshake with the message loader. One instance drives all serial blocks of a hash core.

Parameters:
- W_WORD, 32, serial word width in bits; `counter` wraps at W_WORD-1.
- N_ROUNDS, 64, rounds per block compression.
- HALF_PERIOD, 2, clk cycles per bclk phase (high or low); legal range 1..255.

Ports:
- clk  in  1  system clock; all logic on posedge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  request one block compression; accepted only while ready=1.
- abort  in  1  synchronous abandon of the current block.
- ready  out  1  high in IDLE.
- busy  out  1  high in RUN or FLUSH.
- bclk  out  1  bit clock to the serial datapath.
- counter  out  $clog2(W_WORD)  bit index within the current word; changes only on the clk edge where bclk falls.
- round  out  $clog2(N_ROUNDS)  current round index.
- word_first  out  1  counter==0 while busy.
- word_last  out  1  counter==W_WORD-1 while busy.
- sched_load  out  1  round<16 during RUN: the message word comes from input, not expansion.
- flushing  out  1  high in FLUSH.
- done  out  1  one-cycle pulse when the block completes.

Behaviour:
- Reset (rst=1 at a posedge): next cycle state=IDLE, ready=1, bclk=0, counter=0, round=0, phase=0, all strobes and done=0. Reset mid-operation aborts without a done pulse.
- States and transitions:
  - IDLE -> RUN when start=1. start is ignored in any other state.
  - RUN -> FLUSH after the bclk falling edge that ends bit W_WORD-1 of round N_ROUNDS-1.
  - FLUSH -> DONE after W_WORD further bit periods. During FLUSH, counter runs 0..W_WORD-1 and round holds N_ROUNDS-1. This drains the final word out of the delay lines.
  - DONE -> IDLE unconditionally after one cycle. done=1 only in the DONE cycle.
- abort=1 in RUN or FLUSH: next cycle IDLE, bclk=0, counter=0, round=0, no done pulse. abort in IDLE or DONE has no effect; a DONE cycle still completes. rst has priority over abort, and abort over start.
- bclk generation (RUN/FLUSH):
  - phase counter runs 0..HALF_PERIOD-1.
  - On the edge where phase==HALF_PERIOD-1: bclk toggles and phase returns to 0.
  - bclk is 0 on entry to RUN, so the first rising edge occurs HALF_PERIOD cycles after entry.
  - One bit period is 2*HALF_PERIOD clk cycles.
- counter/round update:
  - Only on the clk edge where bclk goes 1->0, so counter is stable across each bclk rising (record) edge.
  - counter increments modulo W_WORD.
  - On wrap W_WORD-1 -> 0 in RUN, round increments.
  - round never wraps past N_ROUNDS-1.
- Latency (start accepted at cycle 0):
  - RUN occupies cycles 1 .. N_ROUNDS*W_WORD*2*HALF_PERIOD.
  - FLUSH occupies the next W_WORD*2*HALF_PERIOD cycles.
  - DONE is the following cycle.
- bclk is held 0 in IDLE and DONE. Outputs are registered, except word_first, word_last and sched_load, which are combinational decodes of registered state.

Optional Feature:
- Macro: SHA256_SEQ_PAUSE_EN.
- Defined: adds input port `pause` (1 bit).
  - While pause=1 in RUN/FLUSH: phase, bclk, counter and round freeze, so bclk holds its current level.
  - Releasing pause resumes the phase count exactly where it stopped.
  - abort and rst still act immediately during pause.
- Not defined: no pause port; timing is exactly as above.

Test Plan:
- Defaults (W_WORD=32, N_ROUNDS=64, HALF_PERIOD=2), start pulse at cycle 0 -> busy from cycle 1; first bclk rise at cycle 3; flushing high cycles 8193..8320; done=1 only at cycle 8321; ready=1 at 8322.
- HALF_PERIOD=1 -> bclk toggles every cycle. counter changes only on cycles where bclk drops. word_last=1 for exactly one bit period per word. round reaches 63 and holds through FLUSH.
- sched_load check -> high for the first 16*32*2*HALF_PERIOD RUN cycles, low afterwards and during FLUSH.
- start asserted while busy, and again in the DONE cycle -> ignored, no restart; a start in the IDLE cycle after done launches a new block.
- abort at round 10, counter 5 -> next cycle IDLE, bclk=0, counter=0, round=0, no done. Repeat with rst mid-FLUSH -> same result.
- With SHA256_SEQ_PAUSE_EN: pause held 7 cycles while bclk=1 -> bclk stays 1 and counter/round are unchanged; done arrives exactly 7 cycles later than the default case.
